// File: rtl/seq_pattern_detector.sv
// Runtime-configurable serial bit-pattern detector with overlap/non-overlap modes,
// Mealy or Moore match timing and a saturating match counter.
module seq_pattern_detector #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    input  logic               in_valid,
    input  logic               x,
    input  logic               clr_count,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               active
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               overlap_r;
    logic               moore_r;
    logic [MAX_LEN-1:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic               moore_hit_r;
    logic [CNT_W-1:0]   count_r;

    logic               cfg_legal_s;
    logic               accept_s;
    logic               fill_ok_s;
    logic               hit_s;
    logic [MAX_LEN-1:0] mask_s;
    logic [MAX_LEN-1:0] window_s;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

    // Configuration legality and next FSM state.
    always_comb begin
        state_next_s = state_r;
        cfg_legal_s  = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= MAX_LEN_L);
        if (cfg_load) begin
            if (cfg_legal_s) begin
                state_next_s = RUN;
            end else begin
                state_next_s = IDLE;
            end
        end else begin
            state_next_s = state_r;
        end
    end

    // Hit detection: compare the newest len bits (history plus current x) to the pattern.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            if (LEN_W'(i) < len_r) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        window_s  = {hist_r[MAX_LEN-2:0], x};
        accept_s  = (state_r == RUN) && in_valid && !cfg_load;
        // Written as fill+1 >= len so the comparison never underflows.
        fill_ok_s = ({1'b0, fill_r} + {1'b0, LEN_ONE}) >= {1'b0, len_r};
        hit_s     = accept_s && fill_ok_s &&
                    (((window_s ^ pat_r) & mask_s) == {MAX_LEN{1'b0}});
    end

    // Output timing select; a reload suppresses a pending Moore pulse.
    always_comb begin
        match = 1'b0;
        if (moore_r) begin
            match = moore_hit_r && !cfg_load;
        end else begin
            match = hit_s;
        end
    end

    assign match_count = count_r;
    assign active      = (state_r == RUN);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stored configuration, captured on every load regardless of legality.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_r     <= {MAX_LEN{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            overlap_r <= 1'b0;
            moore_r   <= 1'b0;
        end else if (cfg_load) begin
            pat_r     <= cfg_pattern;
            len_r     <= cfg_len;
            overlap_r <= cfg_overlap;
            moore_r   <= cfg_moore;
        end
    end

    // History shift register and saturating fill counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (cfg_load) begin
            hist_r <= {MAX_LEN{1'b0}};
            fill_r <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            hist_r <= window_s;
            if (hit_s && !overlap_r) begin
                fill_r <= {LEN_W{1'b0}};
            end else if (fill_r < MAX_LEN_L) begin
                fill_r <= fill_r + LEN_ONE;
            end
        end
    end

    // Registered copy of hit, shown as the Moore pulse one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            moore_hit_r <= 1'b0;
        end else if (cfg_load) begin
            moore_hit_r <= 1'b0;
        end else begin
            moore_hit_r <= hit_s;
        end
    end

    // Saturating match counter; clear beats a simultaneous hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr_count) begin
            count_r <= {CNT_W{1'b0}};
        end else if (hit_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

endmodule
